// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART_TX between two byte sources,
// with done-wait, optional inter-frame gap and a done-timeout abort.
module uart_tx_arbiter #(
    parameter int GAP_CLKS     = 0,
    parameter int DONE_TIMEOUT = 4096
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Req0,
    input  logic [7:0] i_Byte0,
    output logic       o_Ack0,
    input  logic       i_Req1,
    input  logic [7:0] i_Byte1,
    output logic       o_Ack1,
    output logic       o_TX_DV,
    output logic [7:0] o_TX_Byte,
    input  logic       i_TX_Active,
    input  logic       i_TX_Done,
    output logic       o_Busy,
    output logic       o_Grant,
    output logic       o_Timeout
);
    localparam int TW = $clog2(DONE_TIMEOUT);
    localparam int GW = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(DONE_TIMEOUT - 1);
    localparam logic [GW-1:0] G_LAST = GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT_DONE, GAP} state_e;

    state_e        state_q;
    logic [TW-1:0] tcnt_q;
    logic [GW-1:0] gcnt_q;
    logic          last_q;
    logic          ack0_q, ack1_q, dv_q, to_q, busy_q, grant_q;
    logic [7:0]    byte_q;
    logic          go, pick, leave;

    always_comb begin
        go    = !i_TX_Active && (i_Req0 || i_Req1);
        pick  = (i_Req0 && i_Req1) ? !last_q : i_Req1;
        leave = i_TX_Done || (tcnt_q == T_LAST);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            gcnt_q  <= '0;
            last_q  <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            dv_q    <= 1'b0;
            to_q    <= 1'b0;
            busy_q  <= 1'b0;
            grant_q <= 1'b0;
            byte_q  <= 8'h00;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            dv_q   <= 1'b0;
            to_q   <= 1'b0;
            case (state_q)
                IDLE: if (go) begin
                    byte_q  <= pick ? i_Byte1 : i_Byte0;
                    dv_q    <= 1'b1;
                    ack0_q  <= !pick;
                    ack1_q  <= pick;
                    grant_q <= pick;
                    last_q  <= pick;
                    tcnt_q  <= '0;
                    busy_q  <= 1'b1;
                    state_q <= WAIT_DONE;
                end
                // Done on the expiry cycle wins, so no timeout pulse then.
                WAIT_DONE: if (leave) begin
                    to_q    <= !i_TX_Done;
                    gcnt_q  <= G_LAST;
                    busy_q  <= (GAP_CLKS > 0);
                    state_q <= (GAP_CLKS > 0) ? GAP : IDLE;
                end else begin
                    tcnt_q <= tcnt_q + 1'b1;
                end
                GAP: if (gcnt_q == '0) begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end else begin
                    gcnt_q <= gcnt_q - 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_Ack0    = ack0_q;
    assign o_Ack1    = ack1_q;
    assign o_TX_DV   = dv_q;
    assign o_TX_Byte = byte_q;
    assign o_Busy    = busy_q;
    assign o_Grant   = grant_q;
    assign o_Timeout = to_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized sources and UART_TX stand-in against a
// frame-timeline reference model, for a back-to-back and a gapped instance.
module tb_uart_tx_arbiter;
    localparam int NCYC = 40000;

    logic clk = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g
        localparam int G    = (k == 0) ? 0 : 217;
        localparam int TO   = (k == 0) ? 4096 : 64;
        localparam int RARE = (k == 0) ? 400 : 6;

        logic       rst, tx_active, tx_done;
        logic       req [2];
        logic [7:0] byte_v [2];
        logic       ack0, ack1, dv, busy, grant, tout;
        logic [7:0] tx_byte;
        bit         fin = 1'b0;

        uart_tx_arbiter #(.GAP_CLKS(G), .DONE_TIMEOUT(TO)) dut (
            .i_Clk(clk), .i_Rst(rst),
            .i_Req0(req[0]), .i_Byte0(byte_v[0]), .o_Ack0(ack0),
            .i_Req1(req[1]), .i_Byte1(byte_v[1]), .o_Ack1(ack1),
            .o_TX_DV(dv), .o_TX_Byte(tx_byte),
            .i_TX_Active(tx_active), .i_TX_Done(tx_done),
            .o_Busy(busy), .o_Grant(grant), .o_Timeout(tout)
        );

        // Each frame is a timeline: DV at d, WAIT_DONE leaves at lv, idle from lv+G+1.
        initial begin
            string      pfx;
            int         d, lv, free_at, tx_start, tx_end, done_at, n_end, r;
            bit         last, to_flag, gport;
            logic [7:0] gbyte;
            pfx = (k == 0) ? "g0." : "g217.";
            d = -1000; lv = -1000; free_at = 0;
            tx_start = -1000; tx_end = -1000; done_at = -1000; n_end = -1000;
            last = 1'b1; to_flag = 1'b0; gport = 1'b0; gbyte = 8'h00;
            rst = 1'b1; tx_active = 1'b0; tx_done = 1'b0;
            for (int p = 0; p < 2; p++) begin
                req[p] = 1'b0;
                byte_v[p] = 8'h00;
            end
            for (int c = 0; c < NCYC; c++) begin
                @(negedge clk);
                check({pfx, "dv"},    32'(dv),      32'(c == d));
                check({pfx, "ack0"},  32'(ack0),    32'(c == d && !gport));
                check({pfx, "ack1"},  32'(ack1),    32'(c == d && gport));
                check({pfx, "tout"},  32'(tout),    32'(c == lv + 1 && to_flag));
                check({pfx, "busy"},  32'(busy),    32'(c >= d && c <= lv + G));
                check({pfx, "grant"}, 32'(grant),   32'(gport));
                check({pfx, "byte"},  32'(tx_byte), 32'(gbyte));
                rst = (c < 3) || (c >= d && c <= lv + G && $urandom_range(0, 199) == 0);
                for (int p = 0; p < 2; p++) begin
                    if (c == d && gport == p[0]) begin
                        req[p] = 1'($urandom_range(0, 1));
                        byte_v[p] = 8'($urandom);
                    end else if (req[p]) begin
                        req[p] = ($urandom_range(0, 63) != 0);
                    end else if ($urandom_range(0, 5) == 0) begin
                        req[p] = 1'b1;
                        byte_v[p] = 8'($urandom);
                    end
                end
                if (c > lv && c > tx_end && c > n_end && $urandom_range(0, 39) == 0)
                    n_end = c + $urandom_range(0, 4);
                tx_active = (c >= tx_start && c <= tx_end) || c <= n_end;
                tx_done = (c == done_at) || (!(c >= d && c <= lv) && $urandom_range(0, 15) == 0);
                if (rst) begin
                    d = -1000; lv = -1000; to_flag = 1'b0;
                    gport = 1'b0; gbyte = 8'h00; last = 1'b1; free_at = c + 1;
                end else if (c >= free_at && !tx_active && (req[0] || req[1])) begin
                    gport = (req[0] && req[1]) ? !last : req[1];
                    last = gport;
                    gbyte = byte_v[gport];
                    d = c + 1;
                    tx_start = d + 1;
                    r = $urandom_range(0, RARE - 1);
                    if (r == 0) begin
                        done_at = -1000;
                        lv = d + TO - 1;
                        to_flag = 1'b1;
                    end else begin
                        done_at = (r == 1) ? d + TO - 1 : d + $urandom_range(1, 40);
                        lv = done_at;
                        to_flag = 1'b0;
                    end
                    tx_end = lv + $urandom_range(0, 3);
                    free_at = lv + G + 1;
                end
            end
            fin = 1'b1;
        end
    end

    initial begin
        wait (g[0].fin && g[1].fin);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART_TX instance between two byte sources: port 0, the RX loopback echo, and port 1, a status/message generator.
- Grants requests round-robin and launches one frame at a time: a single-cycle o_TX_DV with the byte held on o_TX_Byte.
- Waits for the transmitter's done pulse, then enforces an optional inter-frame idle gap.
- Recovers from a missing done pulse with a timeout.

Parameters:
- GAP_CLKS, 0, idle clocks inserted after each frame before the next grant (0 = back-to-back).
- DONE_TIMEOUT, 4096, clocks allowed in WAIT_DONE before abort; must exceed 10*CLKS_PER_BIT (2170 at 217).

Ports:
- i_Clk  input  1  system clock
- i_Rst  input  1  synchronous reset, active-high
- i_Req0  input  1  port 0 request; held high with i_Byte0 stable until o_Ack0
- i_Byte0  input  8  port 0 data
- o_Ack0  output  1  one-cycle pulse: port 0 byte accepted
- i_Req1  input  1  port 1 request; held high with i_Byte1 stable until o_Ack1
- i_Byte1  input  8  port 1 data
- o_Ack1  output  1  one-cycle pulse: port 1 byte accepted
- o_TX_DV  output  1  one-cycle start strobe to UART_TX i_TX_DV
- o_TX_Byte  output  8  byte to UART_TX i_TX_Byte, held from strobe until the next grant
- i_TX_Active  input  1  from UART_TX o_TX_Active
- i_TX_Done  input  1  from UART_TX o_TX_Done (one-cycle pulse)
- o_Busy  output  1  high in any state other than IDLE
- o_Grant  output  1  port owning the current or last frame
- o_Timeout  output  1  one-cycle pulse when a frame is aborted

Behaviour:

Clocking and reset:
- Single clock domain; all outputs are registered.
- i_Rst is sampled on the i_Clk edge.
- Reset values: state IDLE; o_Ack0/1, o_TX_DV, o_Timeout, o_Busy all 0; o_TX_Byte 8'h00; o_Grant 0.
- The round-robin pointer resets to "last = port 1", so port 0 wins the first contention.
- Reset mid-frame aborts immediately with no Ack and no Timeout pulse.
- UART_TX is not reset by this block; the i_TX_Active gating below covers the stale frame.

States: IDLE, WAIT_DONE, GAP.

IDLE:
- Arbitrates only when i_TX_Active == 0; otherwise it waits.
- If exactly one request is present, that port wins.
- If both are present, the port not granted last wins.
- On the edge that grants port p:
  - o_TX_Byte <= i_Byte_p
  - o_TX_DV = 1 for one cycle
  - o_Ack_p = 1 for the same cycle
  - o_Grant <= p; pointer <= p
  - state -> WAIT_DONE; timeout counter cleared
- Latency: request seen at edge N gives DV/Ack high during cycle N+1.

WAIT_DONE:
- No new grants; requests are ignored.
- The counter increments each cycle.
- On i_TX_Done = 1: go to GAP if GAP_CLKS > 0, else IDLE.
- If the counter reaches DONE_TIMEOUT-1 without i_TX_Done:
  - o_Timeout pulses for 1 cycle; next state is the same as for Done.
- If i_TX_Done and expiry fall in the same cycle, Done wins and o_Timeout stays 0.
- i_TX_Done seen in IDLE or GAP is ignored.

GAP:
- Lasts exactly GAP_CLKS cycles, then returns to IDLE.

Throughput and request rules:
- With GAP_CLKS = 0: i_TX_Done high in cycle D gives IDLE in D+1 and the next o_TX_DV no earlier than D+2.
- A request that drops before its Ack is simply never granted; there is no error.
- A request still high after its Ack is treated as a new byte.

Widths:
- The timeout counter is clog2(DONE_TIMEOUT) bits.
- The gap counter is max(1, clog2(GAP_CLKS+1)) bits.
- Neither counter wraps: both saturate or reload on state entry.

Test Plan:
1. Single request: i_Req0=1, i_Byte0=8'hA5, GAP_CLKS=0, TX model done after 2170 clks -> one o_TX_DV pulse with o_TX_Byte=A5 and o_Ack0 in the same cycle, o_Grant=0, o_Busy high until the cycle after Done, no second frame once Req0 drops.
2. Contention: both ports request from reset, bytes 8'h11/8'h22, held continuously -> frame order 11, 22, 11, 22; Acks alternate; each DV exactly 2 cycles after the previous Done.
3. Gap: GAP_CLKS=217, Req1 held -> DV-to-DV spacing = frame time + 217 + 2 clocks; no DV during GAP.
4. Timeout: TX model never pulses Done, DONE_TIMEOUT=4096 -> o_Timeout pulses exactly 4096 cycles after DV, then the next pending request is granted. Repeat with Done on the expiry cycle -> no Timeout.
5. Reset mid-frame: assert i_Rst in WAIT_DONE with i_TX_Active high -> all outputs zero the next cycle; no DV until i_TX_Active falls; a late i_TX_Done is ignored; first grant under contention goes to port 0.
6. Request withdrawal: i_Req1 pulsed for 1 cycle while busy -> never acked, never transmitted.
